// File: rtl/usb_tx_scheduler.sv
// ---------------------------------------------------------------------------
// usb_tx_scheduler
//
// Shares the USB TX byte path between two packet sources (source 0: command
// response engine, source 1: debug/event stream). Whole packets are granted
// round-robin. Each packet is framed as token, len[15:8], len[7:0] and then
// the payload bytes, and is written into the TX byte FIFO under tx_full
// backpressure. An abort drops the current packet and flushes the TX FIFO.
//
// Ports
//   clk              system clock, rising edge
//   reset_n          synchronous active-low reset
//   abort            abort current packet, flush TX FIFO (next cycle)
//   req_0/req_1      packet request, held until done_x
//   len_0/len_1      payload byte count, sampled at grant
//   data_0/data_1    show-ahead payload byte of each source
//   grant_0/grant_1  registered: source owns the TX path (header + payload)
//   pop_0/pop_1      current payload byte consumed this cycle
//   done_0/done_1    registered one-cycle pulse, packet fully written
//   busy             registered: scheduler not idle
//   tx_full          TX FIFO full
//   tx_write         TX FIFO write strobe (combinational)
//   tx_wdata         TX FIFO write data
//   tx_flush         registered one-cycle TX FIFO clear
// ---------------------------------------------------------------------------
module usb_tx_scheduler #(
  parameter logic [7:0] TOKEN_0 = 8'h43,
  parameter logic [7:0] TOKEN_1 = 8'h44
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        abort,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [15:0] len_0,
  input  logic [15:0] len_1,
  input  logic [7:0]  data_0,
  input  logic [7:0]  data_1,
  output logic        grant_0,
  output logic        grant_1,
  output logic        pop_0,
  output logic        pop_1,
  output logic        done_0,
  output logic        done_1,
  output logic        busy,
  input  logic        tx_full,
  output logic        tx_write,
  output logic [7:0]  tx_wdata,
  output logic        tx_flush
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_HDR2 = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [15:0] remaining_q, remaining_d;
  logic        grant_0_q, grant_0_d;
  logic        grant_1_q, grant_1_d;
  logic        done_0_q, done_0_d;
  logic        done_1_q, done_1_d;
  logic        busy_q, busy_d;
  logic        tx_flush_q, tx_flush_d;

  logic        in_tx_state;
  logic        arb_sel;
  logic        d_active;

  // States in which the FSM owns the FIFO write port.
  assign in_tx_state = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                       (state_q == S_HDR2) || (state_q == S_DATA);

  // Round-robin pick: on contention the source not granted last wins.
  assign arb_sel = (req_0 && req_1) ? ~last_q : req_1;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      remaining_q <= 16'd0;
      grant_0_q   <= 1'b0;
      grant_1_q   <= 1'b0;
      done_0_q    <= 1'b0;
      done_1_q    <= 1'b0;
      busy_q      <= 1'b0;
      tx_flush_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      grant_0_q   <= grant_0_d;
      grant_1_q   <= grant_1_d;
      done_0_q    <= done_0_d;
      done_1_q    <= done_1_d;
      busy_q      <= busy_d;
      tx_flush_q  <= tx_flush_d;
    end
  end

  // Next-state logic: arbitration, header/payload sequencing, abort override.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (req_0 || req_1) begin
          sel_d       = arb_sel;
          last_d      = arb_sel;
          remaining_d = arb_sel ? len_1 : len_0;
          state_d     = S_HDR0;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_HDR0: begin
        if (tx_write) begin
          state_d = S_HDR1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (tx_write) begin
          state_d = S_HDR2;
        end else begin
          state_d = S_HDR1;
        end
      end
      S_HDR2: begin
        if (tx_write) begin
          state_d = (remaining_q == 16'd0) ? S_DONE : S_DATA;
        end else begin
          state_d = S_HDR2;
        end
      end
      S_DATA: begin
        // remaining counts down to zero exactly; S_DATA is never entered
        // with remaining == 0, so the counter cannot wrap.
        if (tx_write) begin
          remaining_d = remaining_q - 16'd1;
          state_d     = (remaining_q == 16'd1) ? S_DONE : S_DATA;
        end else begin
          state_d     = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over a simultaneous grant or final write; last is kept.
    if (abort) begin
      state_d     = S_IDLE;
      sel_d       = sel_q;
      last_d      = last_q;
      remaining_d = 16'd0;
    end else begin
      state_d     = state_d;
    end
  end

  // Output logic: combinational FIFO strobe/data/pops, next values of the
  // registered status outputs derived from the next state.
  always_comb begin
    tx_write   = in_tx_state && !tx_full && !abort;
    pop_0      = tx_write && (state_q == S_DATA) && !sel_q;
    pop_1      = tx_write && (state_q == S_DATA) && sel_q;

    case (state_q)
      S_HDR0:  tx_wdata = sel_q ? TOKEN_1 : TOKEN_0;
      S_HDR1:  tx_wdata = remaining_q[15:8];
      S_HDR2:  tx_wdata = remaining_q[7:0];
      S_DATA:  tx_wdata = sel_q ? data_1 : data_0;
      default: tx_wdata = 8'h00;
    endcase

    d_active   = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                 (state_d == S_HDR2) || (state_d == S_DATA);
    grant_0_d  = d_active && !sel_d;
    grant_1_d  = d_active && sel_d;
    done_0_d   = (state_d == S_DONE) && !sel_d;
    done_1_d   = (state_d == S_DONE) && sel_d;
    busy_d     = (state_d != S_IDLE);
    tx_flush_d = abort;
  end

  assign grant_0  = grant_0_q;
  assign grant_1  = grant_1_q;
  assign done_0   = done_0_q;
  assign done_1   = done_1_q;
  assign busy     = busy_q;
  assign tx_flush = tx_flush_q;

endmodule
